// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port memory: instruction fetch and
// data access share one memory. At most one transaction is in flight, ties
// alternate between the two requesters, and a wait counter aborts a
// transaction the memory never acknowledges.
module mem_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_stall_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        timeout_o
);

    typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_DM} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_dm_q, last_dm_d;
    logic        timeout_q, timeout_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [7:0]  cnt_inc;
    logic        serving;
    logic        to_hit;
    logic        done;
    logic        if_done;
    logic        dm_done;
    logic        grant_dm;

    // Completion detection and requester-facing combinational outputs.
    // A timeout completes the transaction like an ack, but with zero data;
    // an ack in the same cycle takes precedence and is a normal completion.
    always_comb begin
        serving    = (state_q != IDLE);
        cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        to_hit     = serving && !mem_ack_i && (cnt_inc == TIMEOUT);
        done       = serving && (mem_ack_i || to_hit);
        if_done    = (state_q == SERVE_IF) && done;
        dm_done    = (state_q == SERVE_DM) && done;
        if_stall_o = if_req_i && !if_done;
        dm_stall_o = dm_req_i && !dm_done;
        if_rdata_o = (if_done && mem_ack_i) ? mem_rdata_i : '0;
        dm_rdata_o = (dm_done && mem_ack_i) ? mem_rdata_i : '0;
        // DM wins unless IF also requests and DM was served last.
        grant_dm   = dm_req_i && (!if_req_i || !last_dm_q);
    end

    // Next-state logic: grant in IDLE, wait for ack or timeout in SERVE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_dm_d   = last_dm_q;
        timeout_d   = timeout_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (grant_dm) begin
                    state_d     = SERVE_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                end else if (if_req_i) begin
                    state_d    = SERVE_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr_i;
                end
            end
            SERVE_IF, SERVE_DM: begin
                if (done) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    last_dm_d = (state_q == SERVE_DM);
                    if (to_hit) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    // State and registered memory-side outputs, asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_dm_q   <= 1'b0;
            timeout_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_dm_q   <= last_dm_d;
            timeout_q   <= timeout_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (service order, latency arithmetic, and a
// reference memory image).
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (default TIMEOUT)
    logic        rst_n, if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_stall, dm_stall, mem_req, mem_we, timeout;

    // Second DUT with a short timeout
    logic        rst2, if_req2, dm_req2, dm_we2, mem_ack2;
    logic [31:0] if_addr2, dm_addr2, dm_wdata2, mem_rdata2;
    logic [31:0] if_rdata2, dm_rdata2, mem_addr2, mem_wdata2;
    logic        if_stall2, dm_stall2, mem_req2, mem_we2, timeout2;

    mem_arbiter dut (
        .clk_i(clk), .rst_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_stall_o(if_stall),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_rdata_o(dm_rdata), .dm_stall_o(dm_stall),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .timeout_o(timeout)
    );

    mem_arbiter #(.TIMEOUT(8'd4)) dut2 (
        .clk_i(clk), .rst_i(rst2),
        .if_req_i(if_req2), .if_addr_i(if_addr2), .if_rdata_o(if_rdata2), .if_stall_o(if_stall2),
        .dm_req_i(dm_req2), .dm_we_i(dm_we2), .dm_addr_i(dm_addr2), .dm_wdata_i(dm_wdata2),
        .dm_rdata_o(dm_rdata2), .dm_stall_o(dm_stall2),
        .mem_req_o(mem_req2), .mem_we_o(mem_we2), .mem_addr_o(mem_addr2), .mem_wdata_o(mem_wdata2),
        .mem_ack_i(mem_ack2), .mem_rdata_i(mem_rdata2), .timeout_o(timeout2)
    );

    int unsigned total, bad;

    // Environment memory (responds to the DUT) and reference image (model)
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          ack_delay;
    int          srv_cnt;
    bit          force_ack;
    bit          last_dm_m;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Advance one cycle and play the memory: ack after ack_delay request cycles.
    // Stores return ~wdata as their response word; idle cycles carry noise.
    task automatic tick();
        @(posedge clk);
        #1;
        mem_ack   = force_ack;
        mem_rdata = $urandom();
        if (mem_req) begin
            if (srv_cnt == ack_delay) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_rdata         = ~mem_wdata;
                    env_mem[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : dflt(mem_addr);
                end
            end
            srv_cnt++;
        end else begin
            srv_cnt = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({mem_req, mem_we, timeout} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {mem_req, mem_we, timeout}); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        total++; if ({if_stall, dm_stall} !== 2'b00) begin bad++; $display("FAIL reset_stall: got %b want 00", {if_stall, dm_stall}); end
        rst_n     = 1'b1;
        last_dm_m = 1'b0;
    endtask

    task automatic test_ack_idle();
        force_ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_ack_req: got %b want 0", mem_req); end
            total++; if ({if_rdata, dm_rdata} !== 64'h0) begin bad++; $display("FAIL idle_ack_rdata: got %h want 0", {if_rdata, dm_rdata}); end
        end
        force_ack = 1'b0;
    endtask

    task automatic test_fetch();
        env_mem[32'h100] = 32'hDEADBEEF;
        ref_mem[32'h100] = 32'hDEADBEEF;
        ack_delay = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if_req  = (c <= 1);
            if_addr = 32'h100;
            @(negedge clk);
            if (c == 0) begin
                total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL fetch_stall0: got %b want 1", if_stall); end
                total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fetch_req0: got %b want 0", mem_req); end
            end else if (c == 1) begin
                total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fetch_req1: got %b want 1", mem_req); end
                total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL fetch_addr: got %h want 100", mem_addr); end
                total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL fetch_we: got %b want 0", mem_we); end
                total++; if (if_stall !== 1'b0) begin bad++; $display("FAIL fetch_stall1: got %b want 0", if_stall); end
                total++; if (if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_rdata: got %h want deadbeef", if_rdata); end
            end else begin
                total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fetch_req2: got %b want 0", mem_req); end
            end
        end
        last_dm_m = 1'b0;
    endtask

    task automatic test_store();
        ack_delay = 2;
        for (int c = 0; c < 5; c++) begin
            tick();
            dm_req   = (c <= 3);
            dm_we    = 1'b1;
            dm_addr  = 32'h20;
            dm_wdata = 32'h12345678;
            @(negedge clk);
            if (c <= 3) begin
                total++; if (dm_stall !== (c < 3)) begin bad++; $display("FAIL store_stall c%0d: got %b want %b", c, dm_stall, (c < 3)); end
            end
            if (c == 1) begin
                total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL store_we: got %b want 1", mem_we); end
                total++; if (mem_wdata !== 32'h12345678) begin bad++; $display("FAIL store_wdata: got %h want 12345678", mem_wdata); end
                total++; if (mem_addr !== 32'h20) begin bad++; $display("FAIL store_addr: got %h want 20", mem_addr); end
            end
            if (c == 4) begin
                total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL store_req_end: got %b want 0", mem_req); end
            end
        end
        dm_we   = 1'b0;
        ref_mem[32'h20] = 32'h12345678;
        last_dm_m = 1'b1;
    endtask

    task automatic test_latency();
        int dl[3] = '{0, 1, 5};
        for (int i = 0; i < 3; i++) begin
            int          stall_cnt;
            bit          done;
            logic [31:0] got;
            stall_cnt = 0;
            done      = 1'b0;
            got       = '0;
            ack_delay = dl[i];
            for (int c = 0; c < 20 && !done; c++) begin
                tick();
                if_req  = 1'b1;
                if_addr = 32'h104;
                @(negedge clk);
                if (if_stall) stall_cnt++;
                else begin done = 1'b1; got = if_rdata; end
            end
            tick();
            if_req = 1'b0;
            total++; if (!done) begin bad++; $display("FAIL latency_done d%0d: got no completion want completion", dl[i]); end
            total++; if (stall_cnt != dl[i] + 1) begin bad++; $display("FAIL latency_stall d%0d: got %0d want %0d", dl[i], stall_cnt, dl[i] + 1); end
            total++; if (got !== ref_rd(32'h104)) begin bad++; $display("FAIL latency_data d%0d: got %h want %h", dl[i], got, ref_rd(32'h104)); end
        end
        last_dm_m = 1'b0;
    endtask

    task automatic test_withdraw();
        ack_delay = 3;
        for (int c = 0; c <= 10; c++) begin
            bit exp_req;
            tick();
            dm_req  = (c <= 1);
            dm_we   = 1'b0;
            dm_addr = 32'h108;
            if_req  = (c >= 2 && c <= 9);
            if_addr = 32'h110;
            @(negedge clk);
            exp_req = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
            total++; if (mem_req !== exp_req) begin bad++; $display("FAIL withdraw_req c%0d: got %b want %b", c, mem_req, exp_req); end
            if (c >= 1 && c <= 4) begin
                total++; if (mem_addr !== 32'h108) begin bad++; $display("FAIL withdraw_addr c%0d: got %h want 108", c, mem_addr); end
            end
            if (c >= 2) begin
                total++; if (dm_stall !== 1'b0) begin bad++; $display("FAIL withdraw_dmstall c%0d: got %b want 0", c, dm_stall); end
            end
            if (c >= 2 && c <= 9) begin
                total++; if (if_stall !== (c < 9)) begin bad++; $display("FAIL withdraw_ifstall c%0d: got %b want %b", c, if_stall, (c < 9)); end
            end
            if (c == 6) begin
                total++; if (mem_addr !== 32'h110) begin bad++; $display("FAIL withdraw_ifaddr: got %h want 110", mem_addr); end
            end
            if (c == 9) begin
                total++; if (if_rdata !== ref_rd(32'h110)) begin bad++; $display("FAIL withdraw_ifdata: got %h want %h", if_rdata, ref_rd(32'h110)); end
            end
        end
        last_dm_m = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int unsigned pat;
            bit          want_if, want_dm, first_dm, we;
            int          d, fin_first, fin_second, fin_if, fin_dm, last;
            logic [31:0] ia, da, wd, exp_if, exp_dm;
            pat      = $urandom_range(1, 3);
            want_if  = pat[0];
            want_dm  = pat[1];
            first_dm = want_dm && (!want_if || !last_dm_m);
            d        = int'($urandom_range(0, 4));
            ia       = 32'h200 + ($urandom_range(0, 3) << 2);
            da       = 32'h200 + ($urandom_range(0, 3) << 2);
            wd       = $urandom();
            we       = 1'($urandom_range(0, 1));
            fin_first  = d + 1;
            fin_second = (want_if && want_dm) ? 2 * d + 3 : -1;
            fin_if = !want_if ? -1 : (first_dm ? fin_second : fin_first);
            fin_dm = !want_dm ? -1 : (first_dm ? fin_first : fin_second);
            last   = (fin_second > 0) ? fin_second : fin_first;
            exp_if = '0;
            exp_dm = '0;
            if (first_dm) begin
                exp_dm = we ? ~wd : ref_rd(da);
                if (we) ref_mem[da] = wd;
                if (want_if) exp_if = ref_rd(ia);
            end else begin
                if (want_if) exp_if = ref_rd(ia);
                if (want_dm) begin
                    exp_dm = we ? ~wd : ref_rd(da);
                    if (we) ref_mem[da] = wd;
                end
            end
            ack_delay = d;
            for (int c = 0; c <= last + 1; c++) begin
                bit exp_req, served_dm;
                tick();
                if_req   = want_if && (c <= fin_if);
                if_addr  = ia;
                dm_req   = want_dm && (c <= fin_dm);
                dm_addr  = da;
                dm_we    = we;
                dm_wdata = wd;
                @(negedge clk);
                exp_req = (c >= 1 && c <= d + 1) || (fin_second > 0 && c >= d + 3 && c <= fin_second);
                total++; if (mem_req !== exp_req) begin bad++; $display("FAIL rnd_req it%0d c%0d: got %b want %b", it, c, mem_req, exp_req); end
                if (exp_req) begin
                    served_dm = (c <= d + 1) ? first_dm : !first_dm;
                    total++; if (mem_addr !== (served_dm ? da : ia)) begin bad++; $display("FAIL rnd_addr it%0d c%0d: got %h want %h", it, c, mem_addr, served_dm ? da : ia); end
                    total++; if (mem_we !== (served_dm && we)) begin bad++; $display("FAIL rnd_we it%0d c%0d: got %b want %b", it, c, mem_we, served_dm && we); end
                    if (served_dm && we) begin
                        total++; if (mem_wdata !== wd) begin bad++; $display("FAIL rnd_wdata it%0d c%0d: got %h want %h", it, c, mem_wdata, wd); end
                    end
                end
                total++; if (if_stall !== (if_req && c != fin_if)) begin bad++; $display("FAIL rnd_ifstall it%0d c%0d: got %b want %b", it, c, if_stall, (if_req && c != fin_if)); end
                total++; if (dm_stall !== (dm_req && c != fin_dm)) begin bad++; $display("FAIL rnd_dmstall it%0d c%0d: got %b want %b", it, c, dm_stall, (dm_req && c != fin_dm)); end
                total++; if (if_rdata !== ((want_if && c == fin_if) ? exp_if : 32'h0)) begin bad++; $display("FAIL rnd_ifdata it%0d c%0d: got %h want %h", it, c, if_rdata, (want_if && c == fin_if) ? exp_if : 32'h0); end
                total++; if (dm_rdata !== ((want_dm && c == fin_dm) ? exp_dm : 32'h0)) begin bad++; $display("FAIL rnd_dmdata it%0d c%0d: got %h want %h", it, c, dm_rdata, (want_dm && c == fin_dm) ? exp_dm : 32'h0); end
            end
            last_dm_m = (want_if && want_dm) ? !first_dm : first_dm;
        end
    endtask

    task automatic test_fairness();
        logic [31:0] grants[$];
        logic [31:0] exp_seq[4] = '{32'h2000, 32'h1000, 32'h2000, 32'h1000};
        bit          prev;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        ack_delay = 0;
        prev      = 1'b0;
        for (int c = 0; c < 24 && grants.size() < 4; c++) begin
            tick();
            if_req  = 1'b1;
            if_addr = 32'h1000;
            dm_req  = 1'b1;
            dm_we   = 1'b0;
            dm_addr = 32'h2000;
            @(negedge clk);
            if (mem_req && !prev) grants.push_back(mem_addr);
            prev = mem_req;
        end
        tick();
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        total++; if (grants.size() != 4) begin bad++; $display("FAIL fair_count: got %0d want 4", grants.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) begin
                total++; if (grants[i] !== exp_seq[i]) begin bad++; $display("FAIL fair_grant%0d: got %h want %h", i, grants[i], exp_seq[i]); end
            end
        end
        last_dm_m = 1'b0;
    endtask

    task automatic test_reset_midserve();
        ack_delay = 100;
        tick();
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h10C;
        dm_wdata = 32'hCAFEF00D;
        @(negedge clk);
        tick();
        @(negedge clk);
        total++; if ({mem_req, mem_we} !== 2'b11) begin bad++; $display("FAIL midrst_serving: got %b want 11", {mem_req, mem_we}); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({mem_req, mem_we} !== 2'b00) begin bad++; $display("FAIL midrst_async: got %b want 00", {mem_req, mem_we}); end
        total++; if ({mem_addr, mem_wdata} !== 64'h0) begin bad++; $display("FAIL midrst_regs: got %h want 0", {mem_addr, mem_wdata}); end
        dm_req = 1'b0;
        dm_we  = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        last_dm_m = 1'b0;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        @(negedge clk);
        total++; if ({mem_req, dm_rdata} !== 33'h0) begin bad++; $display("FAIL midrst_stale_ack: got %h want 0", {mem_req, dm_rdata}); end
        ack_delay = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if_req  = (c <= 1);
            if_addr = 32'h10C;
            @(negedge clk);
            if (c == 0) begin
                total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL midrst_if_stall0: got %b want 1", if_stall); end
            end else if (c == 1) begin
                total++; if (mem_addr !== 32'h10C) begin bad++; $display("FAIL midrst_if_addr: got %h want 10c", mem_addr); end
                total++; if (if_stall !== 1'b0) begin bad++; $display("FAIL midrst_if_stall1: got %b want 0", if_stall); end
                total++; if (if_rdata !== ref_rd(32'h10C)) begin bad++; $display("FAIL midrst_if_data: got %h want %h", if_rdata, ref_rd(32'h10C)); end
            end else begin
                total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL midrst_if_end: got %b want 0", mem_req); end
            end
        end
        last_dm_m = 1'b0;
    endtask

    task automatic test_timeout();
        @(negedge clk);
        rst2 = 1'b1;
        // Ack in the fourth serve cycle: normal completion, no timeout
        for (int c = 0; c <= 5; c++) begin
            @(posedge clk);
            #1;
            dm_req2    = (c <= 4);
            dm_addr2   = 32'h40;
            dm_we2     = 1'b0;
            mem_ack2   = (c == 4);
            mem_rdata2 = (c == 4) ? 32'h0BADF00D : $urandom();
            @(negedge clk);
            total++; if (mem_req2 !== (c >= 1 && c <= 4)) begin bad++; $display("FAIL to_edge_req c%0d: got %b want %b", c, mem_req2, (c >= 1 && c <= 4)); end
            if (c <= 4) begin
                total++; if (dm_stall2 !== (c < 4)) begin bad++; $display("FAIL to_edge_stall c%0d: got %b want %b", c, dm_stall2, (c < 4)); end
            end
            if (c == 4) begin
                total++; if (dm_rdata2 !== 32'h0BADF00D) begin bad++; $display("FAIL to_edge_data: got %h want 0badf00d", dm_rdata2); end
            end
            total++; if (timeout2 !== 1'b0) begin bad++; $display("FAIL to_edge_flag c%0d: got %b want 0", c, timeout2); end
        end
        // No ack at all: four serve cycles, then forced completion and sticky flag
        for (int c = 0; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if_req2    = (c <= 4);
            if_addr2   = 32'h80;
            mem_ack2   = 1'b0;
            mem_rdata2 = $urandom() | 32'h1;
            @(negedge clk);
            total++; if (mem_req2 !== (c >= 1 && c <= 4)) begin bad++; $display("FAIL to_req c%0d: got %b want %b", c, mem_req2, (c >= 1 && c <= 4)); end
            if (c <= 4) begin
                total++; if (if_stall2 !== (c < 4)) begin bad++; $display("FAIL to_stall c%0d: got %b want %b", c, if_stall2, (c < 4)); end
                total++; if (if_rdata2 !== 32'h0) begin bad++; $display("FAIL to_rdata c%0d: got %h want 0", c, if_rdata2); end
            end
            if (c <= 3) begin
                total++; if (timeout2 !== 1'b0) begin bad++; $display("FAIL to_flag_early c%0d: got %b want 0", c, timeout2); end
            end
            if (c >= 5) begin
                total++; if (timeout2 !== 1'b1) begin bad++; $display("FAIL to_flag c%0d: got %b want 1", c, timeout2); end
            end
        end
        rst2 = 1'b0;
        #1;
        total++; if (timeout2 !== 1'b0) begin bad++; $display("FAIL to_flag_reset: got %b want 0", timeout2); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; rst2 = 1'b0;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        if_req2 = 1'b0; dm_req2 = 1'b0; dm_we2 = 1'b0; mem_ack2 = 1'b0;
        if_addr2 = '0; dm_addr2 = '0; dm_wdata2 = '0; mem_rdata2 = '0;
        ack_delay = 0; srv_cnt = 0; force_ack = 1'b0; last_dm_m = 1'b0;
        test_reset();
        test_ack_idle();
        test_fetch();
        test_store();
        test_latency();
        test_withdraw();
        test_random();
        test_fairness();
        test_reset_midserve();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
